rpn_evaluator: RTL and testbench
================================

// Module: rpn_evaluator
// PURPOSE
//   Postfix (RPN) expression evaluator that sits upstream of and owns the LIFO operand store.
//   Consumes a token stream (operands/operators) over valid/ready.
//   Drives all push/pop traffic on the store; emits one result + error code per expression.
//   Expression boundary marked by tok_last; evaluator is then ready for the next expression.
// PARAMETERS
//   WIDTH  11  data/operand width, bits
//   DEPTH   7  log2 of stack entries (capacity 2**DEPTH = 128)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      reset, synchronous, active-high
//   tok_valid  in   1      token present
//   tok_ready  out  1      evaluator accepts token this cycle
//   tok_is_op  in   1      1 = operator (opcode in tok_data[1:0]), 0 = operand
//   tok_data   in   WIDTH  operand value or opcode
//   tok_last   in   1      final token of expression
//   res_valid  out  1      result/error available
//   res_ready  in   1      downstream accepts result
//   res_data   out  WIDTH  expression value (0 on error)
//   res_err    out  2      00 ok, 01 underflow, 10 overflow, 11 leftover depth != 1
// BEHAVIOUR
//   - Reset: state IDLE, cnt=0, err=00, tok_ready=0 in reset cycle then 1, res_valid=0, res_data=0.
//     Reset mid-expression discards all state; no result is emitted for the aborted expression.
//   - Storage: top-of-stack held in register TOS; entries below TOS in lifo_mem.
//     cnt (DEPTH+1 bits) = number of live entries; mem holds cnt-1.
//   - Token accepted when tok_valid & tok_ready. tok_ready=1 only in IDLE and DRAIN.
//   - FSM states IDLE, EXEC, DRAIN, DONE.
//   - IDLE, operand:
//     - cnt == 2**DEPTH: err=10, enter DRAIN (or DONE if tok_last).
//     - else mem[cnt-1]<=TOS (if cnt>0), TOS<=tok_data, cnt++.
//     - 1 token/cycle throughput.
//   - IDLE, operator:
//     - cnt < 2: err=01, enter DRAIN (or DONE if tok_last).
//     - else issue sync read of mem[cnt-2] (NOS), latch opcode and tok_last, go EXEC.
//   - EXEC (1 cycle, tok_ready=0): TOS <= NOS op TOS; cnt--.
//     Opcodes: 00 add, 01 sub (NOS-TOS), 10 mul (low WIDTH bits), 11 bitwise and.
//     All arithmetic modulo 2**WIDTH; no saturation, no flags.
//     Operator latency 2 cycles. Returns to IDLE, or DONE if the latched tok_last is set.
//   - tok_last on an operand: push completes, then DONE next cycle.
//     On DONE entry: if err==00 and cnt != 1, err=11.
//   - DRAIN: accept and discard tokens until tok_last, then DONE. No stack activity.
//   - DONE:
//     - res_valid=1; res_data=TOS if err==00 else 0; res_err=err.
//     - Held stable while res_ready=0.
//     - On res_valid & res_ready: cnt=0, err=00, go IDLE next cycle.
//   - First error wins; later errors in the same expression are ignored.
//   - Simultaneous tok_valid in DONE is not accepted (tok_ready=0).
// STRUCTURE
//   - Shared package rpn_pkg: opcode localparams (OP_ADD/SUB/MUL/AND), error codes
//     (ERR_OK/UNDER/OVER/DEPTH), FSM state encoding.
//   - Sub-module lifo_mem: sync-write/sync-read RAM.
//     WIDTH x 2**DEPTH, ports we, waddr, wdata, raddr, rdata (1-cycle read latency).
//   - Top holds FSM, TOS register, cnt, ALU (combinational case on latched opcode).
// TESTING
//   1. "3 4 + 5 *" last on '*'
//      -> res_data=35, err=00; operator tokens see tok_ready drop 1 cycle.
//   2. "2 5 -" -> res_data=2045 (wrap), err=00.
//      "64 64 *" -> res_data=0 (4096 mod 2048).
//   3. "7 +" then "1 1 +"
//      -> first result err=01, data 0; second result 2, err=00 (recovery).
//   4. 129 operands, last on 129th -> err=10 after 128 pushes.
//      Then "9" -> 9, err=00.
//   5. "1 2" last on '2' -> err=11, data 0.
//      Hold res_ready=0 for 5 cycles -> outputs stable, tok_ready=0.
//   6. Assert reset during "3 4" mid-stream; then send "6"
//      -> single result 6, err=00, no stale result emitted.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: default sizes, opcodes,
// result error codes and the evaluator FSM state encoding.
// Imported by rpn_evaluator and lifo_mem.
package rpn_pkg;

    // Default operand width and log2 of stack capacity.
    localparam int RPN_WIDTH = 11;
    localparam int RPN_DEPTH = 7;

    // Operator encodings carried in tok_data[1:0] when tok_is_op is set.
    localparam logic [1:0] OP_ADD = 2'b00;  // NOS + TOS
    localparam logic [1:0] OP_SUB = 2'b01;  // NOS - TOS
    localparam logic [1:0] OP_MUL = 2'b10;  // low WIDTH bits of NOS * TOS
    localparam logic [1:0] OP_AND = 2'b11;  // NOS & TOS

    // Per-expression error codes reported on res_err.
    localparam logic [1:0] ERR_OK    = 2'b00;  // clean evaluation
    localparam logic [1:0] ERR_UNDER = 2'b01;  // operator with fewer than two entries
    localparam logic [1:0] ERR_OVER  = 2'b10;  // operand pushed onto a full stack
    localparam logic [1:0] ERR_DEPTH = 2'b11;  // expression ended with depth != 1

    // Evaluator FSM states.
    //   ST_IDLE  : accepting tokens, performing pushes / launching operators
    //   ST_EXEC  : NOS read returns, ALU result written into TOS
    //   ST_DRAIN : error seen, discarding tokens up to tok_last
    //   ST_DONE  : presenting result until downstream accepts it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/rpn_evaluator_lifo_mem.sv
// Operand store for the entries below top-of-stack: WIDTH x 2**DEPTH RAM.
// Latency: write lands on the clock edge; read data appears one cycle after raddr.
// Backpressure: none; the owner sequences every access.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (sampled every cycle)
//   rdata  registered read data for the previous cycle's raddr
module lifo_mem
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH,
    parameter int DEPTH = RPN_DEPTH
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // Plain storage with no reset: the live region is always defined by the
    // owner's entry count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/rpn_evaluator.sv
// Postfix (RPN) expression evaluator owning its operand stack; one result per expression.
// Latency: operand 1 cycle (1 token/cycle), operator 2 cycles; result 1 cycle after last token completes.
// Backpressure: tok_ready low during operator execute and while a result waits for res_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; aborts any expression in flight
//   tok_valid  token present
//   tok_ready  evaluator accepts token this cycle (registered)
//   tok_is_op  1 = operator (opcode in tok_data[1:0]), 0 = operand
//   tok_data   operand value or opcode
//   tok_last   final token of the expression
//   res_valid  result/error available
//   res_ready  downstream accepts result
//   res_data   expression value, 0 when an error was reported
//   res_err    00 ok, 01 underflow, 10 overflow, 11 leftover depth != 1
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH,
    parameter int DEPTH = RPN_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    input  logic             tok_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_err
);

    // Entry-count constants sized to cnt (DEPTH+1 bits so a full stack is representable).
    localparam int             CAP_INT  = 2**DEPTH;
    localparam logic [DEPTH:0] CNT_ZERO = '0;
    localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] CNT_TWO  = (DEPTH+1)'(2);
    localparam logic [DEPTH:0] CNT_CAP  = (DEPTH+1)'(CAP_INT);

    // Address offsets into the RAM, which holds entries 0 .. cnt-2.
    localparam logic [DEPTH-1:0] ADDR_ONE = DEPTH'(1);
    localparam logic [DEPTH-1:0] ADDR_TWO = DEPTH'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    logic [WIDTH-1:0] tos;      // top-of-stack register
    logic [DEPTH:0]   cnt;      // live entries including TOS
    logic [1:0]       err;      // first error of the current expression
    logic [1:0]       op_q;     // opcode latched for the execute cycle
    logic             last_q;   // tok_last latched with the operator

    // ------------------------------------------------------------------
    // Handshakes and derived values
    // ------------------------------------------------------------------
    logic             tok_fire;
    logic             res_fire;
    logic [DEPTH:0]   cnt_inc;
    logic [DEPTH:0]   cnt_dec;

    assign tok_fire = tok_valid & tok_ready;
    assign res_fire = res_valid & res_ready;
    assign cnt_inc  = cnt + CNT_ONE;
    assign cnt_dec  = cnt - CNT_ONE;

    // ------------------------------------------------------------------
    // Operand store below TOS
    // ------------------------------------------------------------------
    logic             mem_we;
    logic [DEPTH-1:0] mem_waddr;
    logic [DEPTH-1:0] mem_raddr;
    logic [WIDTH-1:0] nos;

    // A push spills the old TOS into slot cnt-1, but only when there was a
    // TOS to spill and the stack is not already full.
    assign mem_we    = (state == ST_IDLE) && tok_fire && !tok_is_op
                       && (cnt != CNT_ZERO) && (cnt != CNT_CAP);
    assign mem_waddr = cnt[DEPTH-1:0] - ADDR_ONE;

    // NOS lives at slot cnt-2. The RAM reads every cycle; the value is only
    // consumed in EXEC, which always follows the IDLE cycle that accepted the
    // operator with cnt unchanged, so rdata is NOS exactly when it is needed.
    assign mem_raddr = cnt[DEPTH-1:0] - ADDR_TWO;

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (tos),
        .raddr (mem_raddr),
        .rdata (nos)
    );

    // ------------------------------------------------------------------
    // ALU: combinational on the latched opcode, all results modulo 2**WIDTH.
    // The multiply is evaluated in a WIDTH-bit context, which keeps exactly
    // the low WIDTH bits of the product.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = nos + tos;
            OP_SUB:  alu_res = nos - tos;
            OP_MUL:  alu_res = nos * tos;
            OP_AND:  alu_res = nos & tos;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Evaluator FSM. tok_ready is registered and tracks the state being
    // entered: high for IDLE/DRAIN, low for EXEC/DONE and during reset.
    // Errors are only ever raised from IDLE or on entry to DONE from a clean
    // path, so err is still ERR_OK at each of those points and the first
    // error of an expression is the one that is kept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tos       <= '0;
            cnt       <= '0;
            err       <= ERR_OK;
            op_q      <= OP_ADD;
            last_q    <= 1'b0;
            tok_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tok_ready <= 1'b1;
                    if (tok_fire) begin
                        if (!tok_is_op) begin
                            if (cnt == CNT_CAP) begin
                                err       <= ERR_OVER;
                                state     <= tok_last ? ST_DONE : ST_DRAIN;
                                tok_ready <= !tok_last;
                            end else begin
                                tos <= tok_data;
                                cnt <= cnt_inc;
                                if (tok_last) begin
                                    state     <= ST_DONE;
                                    tok_ready <= 1'b0;
                                    // After this push the depth is cnt+1;
                                    // anything but a single entry is leftover.
                                    if (cnt != CNT_ZERO) begin
                                        err <= ERR_DEPTH;
                                    end
                                end
                            end
                        end else begin
                            if (cnt < CNT_TWO) begin
                                err       <= ERR_UNDER;
                                state     <= tok_last ? ST_DONE : ST_DRAIN;
                                tok_ready <= !tok_last;
                            end else begin
                                op_q      <= tok_data[1:0];
                                last_q    <= tok_last;
                                state     <= ST_EXEC;
                                tok_ready <= 1'b0;
                            end
                        end
                    end
                end

                ST_EXEC: begin
                    tos <= alu_res;
                    cnt <= cnt_dec;
                    if (last_q) begin
                        state     <= ST_DONE;
                        tok_ready <= 1'b0;
                        // Depth after the pop is cnt-1; it must be exactly one.
                        if (cnt != CNT_TWO) begin
                            err <= ERR_DEPTH;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        tok_ready <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    tok_ready <= 1'b1;
                    if (tok_fire && tok_last) begin
                        state     <= ST_DONE;
                        tok_ready <= 1'b0;
                    end
                end

                ST_DONE: begin
                    tok_ready <= 1'b0;
                    if (res_fire) begin
                        cnt       <= '0;
                        err       <= ERR_OK;
                        state     <= ST_IDLE;
                        tok_ready <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    tok_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result presentation: decoded straight from registered state, so it is
    // stable for as long as DONE is held by res_ready.
    // ------------------------------------------------------------------
    assign res_valid = (state == ST_DONE);
    assign res_data  = (state == ST_DONE && err == ERR_OK) ? tos : '0;
    assign res_err   = err;

endmodule

// File: tb/tb_rpn_evaluator.sv
module tb_rpn_evaluator;

    localparam int WIDTH = 11;
    localparam int DEPTH = 7;

    // Token encoding for the vector table: bit 11 = is_op, bits 10:0 = data.
    localparam logic [11:0] T_ADD = 12'h800;
    localparam logic [11:0] T_SUB = 12'h801;
    localparam logic [11:0] T_MUL = 12'h802;
    localparam logic [11:0] T_AND = 12'h803;

    logic             clk;
    logic             reset;
    logic             tok_valid;
    logic             tok_ready;
    logic             tok_is_op;
    logic [WIDTH-1:0] tok_data;
    logic             tok_last;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [1:0]       res_err;

    rpn_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_is_op (tok_is_op),
        .tok_data  (tok_data),
        .tok_last  (tok_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [5:0][11:0] tok;
        logic [2:0]       n;
        logic [10:0]      exp_d;
        logic [1:0]       exp_e;
    } vec_t;

    int          checks;
    int          failures;
    string       cur;
    logic [12:0] exp_q[$];   // {expected res_data, expected res_err}
    vec_t        vecs[13];

    function automatic vec_t mk(input logic [10:0] d, input logic [1:0] e, input int n,
                                input logic [11:0] t0, input logic [11:0] t1 = 12'd0,
                                input logic [11:0] t2 = 12'd0, input logic [11:0] t3 = 12'd0,
                                input logic [11:0] t4 = 12'd0, input logic [11:0] t5 = 12'd0);
        vec_t r;
        r.tok[0] = t0; r.tok[1] = t1; r.tok[2] = t2;
        r.tok[3] = t3; r.tok[4] = t4; r.tok[5] = t5;
        r.n      = 3'(n);
        r.exp_d  = d;
        r.exp_e  = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, cur, act, exp);
        end
    endtask

    // Scoreboard side: called once per cycle with the inputs for the coming
    // edge already applied, so a visible handshake is exactly one transfer.
    task automatic mon();
        logic [12:0] e;
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result [%s]: got data=%0d err=%0d expected none",
                         cur, res_data, res_err);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", 32'(res_data), 32'(e[12:2]));
                chk("res_err", 32'(res_err), 32'(e[1:0]));
            end
        end
    endtask

    // One cycle: observe, then advance to the next falling edge.
    task automatic step();
        mon();
        @(negedge clk);
    endtask

    task automatic send_tok(input logic is_op, input logic [WIDTH-1:0] d, input logic last);
        logic acc;
        int   n;
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        tok_last  = last;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            acc = tok_ready;
            step();
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL tok_accept_timeout [%s]: got tok_ready=0 for %0d cycles expected accept", cur, n);
        end
        tok_valid = 1'b0;
        tok_last  = 1'b0;
    endtask

    task automatic wait_results();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout [%s]: got %0d results pending expected 0", cur, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cur       = "reset";
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
        tok_last  = 1'b0;
        res_ready = 1'b1;

        vecs[0]  = mk(11'd35,   2'd0, 5, 12'd3, 12'd4, T_ADD, 12'd5, T_MUL);
        vecs[1]  = mk(11'd2045, 2'd0, 3, 12'd2, 12'd5, T_SUB);
        vecs[2]  = mk(11'd0,    2'd0, 3, 12'd64, 12'd64, T_MUL);
        vecs[3]  = mk(11'd0,    2'd1, 2, 12'd7, T_ADD);
        vecs[4]  = mk(11'd2,    2'd0, 3, 12'd1, 12'd1, T_ADD);
        vecs[5]  = mk(11'd0,    2'd3, 2, 12'd1, 12'd2);
        vecs[6]  = mk(11'd8,    2'd0, 3, 12'd12, 12'd10, T_AND);
        vecs[7]  = mk(11'd4,    2'd0, 5, 12'd5, 12'd3, T_SUB, 12'd2, T_MUL);
        vecs[8]  = mk(11'd0,    2'd1, 1, T_ADD);
        vecs[9]  = mk(11'd0,    2'd1, 5, 12'd1, T_ADD, 12'd2, 12'd3, T_ADD);
        vecs[10] = mk(11'd0,    2'd3, 4, 12'd1, 12'd2, 12'd3, T_ADD);
        vecs[11] = mk(11'd2046, 2'd0, 3, 12'd2047, 12'd2, T_MUL);
        vecs[12] = mk(11'd100,  2'd0, 1, 12'd100);

        // Reset state
        @(negedge clk);
        step();
        step();
        chk("reset_tok_ready", 32'(tok_ready), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_res_data", 32'(res_data), 32'd0);
        chk("reset_res_err", 32'(res_err), 32'd0);
        reset = 1'b0;
        step();
        chk("post_reset_tok_ready", 32'(tok_ready), 32'd1);

        // "3 4 + 5 *": operator drops tok_ready for exactly one cycle
        cur = "tok_ready_drop";
        exp_q.push_back({11'd35, 2'd0});
        send_tok(1'b0, 11'd3, 1'b0);
        send_tok(1'b0, 11'd4, 1'b0);
        send_tok(1'b1, 11'd0, 1'b0);
        chk("exec_tok_ready", 32'(tok_ready), 32'd0);
        step();
        chk("after_exec_tok_ready", 32'(tok_ready), 32'd1);
        send_tok(1'b0, 11'd5, 1'b0);
        send_tok(1'b1, 11'd2, 1'b1);
        wait_results();

        // Table-driven expressions
        for (int v = 0; v < 13; v++) begin
            cur = $sformatf("vec%0d", v);
            exp_q.push_back({vecs[v].exp_d, vecs[v].exp_e});
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                send_tok(vecs[v].tok[k][11], vecs[v].tok[k][10:0], k == int'(vecs[v].n) - 1);
            end
            wait_results();
        end

        // Overflow: 129 operands, then recovery
        cur = "overflow";
        exp_q.push_back({11'd0, 2'd2});
        for (int i = 1; i <= 129; i++) begin
            send_tok(1'b0, 11'(i), i == 129);
        end
        wait_results();
        cur = "overflow_recover";
        exp_q.push_back({11'd9, 2'd0});
        send_tok(1'b0, 11'd9, 1'b1);
        wait_results();

        // Leftover depth with res_ready held low; a pending token must wait
        cur = "hold";
        exp_q.push_back({11'd0, 2'd3});
        exp_q.push_back({11'd5, 2'd0});
        res_ready = 1'b0;
        send_tok(1'b0, 11'd1, 1'b0);
        send_tok(1'b0, 11'd2, 1'b1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 20) begin
                step();
                n++;
            end
        end
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = 11'd5;
        tok_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'd0);
            chk("hold_res_err", 32'(res_err), 32'd3);
            chk("hold_tok_ready", 32'(tok_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        begin
            logic acc;
            int   n;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 20) begin
                acc = tok_ready;
                step();
                n++;
            end
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL hold_token_accept [%s]: got tok_ready=0 expected accept", cur);
            end
        end
        tok_valid = 1'b0;
        tok_last  = 1'b0;
        wait_results();

        // Reset mid-expression discards everything
        cur = "mid_reset";
        send_tok(1'b0, 11'd3, 1'b0);
        send_tok(1'b0, 11'd4, 1'b0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("mid_reset_res_valid", 32'(res_valid), 32'd0);
        chk("mid_reset_tok_ready", 32'(tok_ready), 32'd1);
        exp_q.push_back({11'd6, 2'd0});
        send_tok(1'b0, 11'd6, 1'b1);
        wait_results();
        for (int k = 0; k < 10; k++) begin
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
